// File: rtl/x_therm_to_bin_pkg.sv
// Shared helpers for the thermometer-to-binary loopback decoder.
// Pin mapping of the edge-interleaved word and derived width helpers.
package x_therm_pkg;

  // Pin index that carries linear thermometer bit i (even bits from the low edge, odd from the high)
  function automatic int unsigned therm_lin_idx(input int unsigned i, input int unsigned n);
    return ((i % 2) == 0) ? (i / 2) : (n - 1 - (i / 2));
  endfunction

  function automatic int unsigned bin_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  function automatic int unsigned grp_cnt(input int unsigned n, input int unsigned g);
    return n / g;
  endfunction

endpackage

// File: rtl/x_therm_to_bin_if.sv
// Sample-in / result-out bundle for x_therm_to_bin.
// The master drives samples and the clear request; the slave (the decoder) returns results.
interface x_therm_to_bin_if
  import x_therm_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned ERR_W = 16
);
  localparam int unsigned BW = bin_w(N);

  logic             i_valid;
  logic [N-1:0]     i_therm;
  logic             i_clr_err;
  logic             o_valid;
  logic [BW-1:0]    o_bin;
  logic             o_err;
  logic             o_err_sticky;
  logic [ERR_W-1:0] o_err_cnt;

  modport master (
    output i_valid, i_therm, i_clr_err,
    input  o_valid, o_bin, o_err, o_err_sticky, o_err_cnt
  );

  modport slave (
    input  i_valid, i_therm, i_clr_err,
    output o_valid, o_bin, o_err, o_err_sticky, o_err_cnt
  );
endinterface

// File: rtl/x_therm_to_bin_popcount.sv
// Combinational ones-count of a W-bit vector.
module x_popcount #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]       i_vec,
  output logic [$clog2(W):0] o_cnt_c
);
  localparam int unsigned CW = $clog2(W) + 1;

  always_comb begin
    o_cnt_c = '0;
    for (int unsigned k = 0; k < W; k++) begin
      o_cnt_c = o_cnt_c + CW'(i_vec[k]);
    end
  end
endmodule

// File: rtl/x_therm_to_bin.sv
// Three-stage thermometer-to-binary decoder with bubble detection and error tracking.
// De-interleaves the DAC pin order, counts ones, and flags non-monotonic codes.
module x_therm_to_bin
  import x_therm_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned GROUP = 8,
  parameter int unsigned ERR_W = 16
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  x_therm_to_bin_if.slave io_bus
);
  localparam int unsigned BW  = bin_w(N);
  localparam int unsigned GRP = grp_cnt(N, GROUP);
  localparam int unsigned PW  = $clog2(GROUP) + 1;

  logic [N-1:0]     w_lin;
  logic [N-1:0]     r_lin;
  logic             r_v1;

  logic [PW-1:0]    w_part [GRP];
  logic [PW-1:0]    r_part [GRP];
  logic             w_bub;
  logic             r_bub;
  logic             r_v2;

  logic [BW-1:0]    w_sum;
  logic [BW-1:0]    r_bin;
  logic             r_err;
  logic             r_v3;

  logic             r_sticky;
  logic [ERR_W-1:0] r_cnt;

  // Pin order back to linear thermometer order (wiring only)
  for (genvar gi = 0; gi < N; gi++) begin : g_lin
    assign w_lin[gi] = io_bus.i_therm[therm_lin_idx(gi, N)];
  end

  // S1: capture linear word; the word is sampled regardless of valid
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_lin <= '0;
      r_v1  <= 1'b0;
    end else begin
      r_lin <= w_lin;
      r_v1  <= io_bus.i_valid;
    end
  end

  // S2: per-group popcounts and bubble detect (a one above a zero)
  for (genvar g = 0; g < GRP; g++) begin : g_pc
    x_popcount #(.W(GROUP)) u_pc (
      .i_vec   (r_lin[g*GROUP +: GROUP]),
      .o_cnt_c (w_part[g])
    );
  end

  assign w_bub = |(r_lin[N-1:1] & ~r_lin[N-2:0]);

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_part <= '{default: '0};
      r_bub  <= 1'b0;
      r_v2   <= 1'b0;
    end else begin
      r_part <= w_part;
      r_bub  <= w_bub;
      r_v2   <= r_v1;
    end
  end

  // S3: partial-sum adder; BW bits always hold the full count 0..N
  always_comb begin
    w_sum = '0;
    for (int unsigned g = 0; g < GRP; g++) begin
      w_sum = w_sum + BW'(r_part[g]);
    end
  end

  // Result registers hold their last value across invalid cycles
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_bin <= '0;
      r_err <= 1'b0;
      r_v3  <= 1'b0;
    end else begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_bin <= w_sum;
        r_err <= r_bub;
      end
    end
  end

  // Error tracker: clear has priority over a same-cycle error update
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (io_bus.i_clr_err) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (r_v3 && r_err) begin
      r_sticky <= 1'b1;
      if (r_cnt != '1) begin
        r_cnt <= r_cnt + ERR_W'(1);
      end
    end
  end

  assign io_bus.o_valid      = r_v3;
  assign io_bus.o_bin        = r_bin;
  assign io_bus.o_err        = r_err;
  assign io_bus.o_err_sticky = r_sticky;
  assign io_bus.o_err_cnt    = r_cnt;

endmodule
